rep_pixel_scaler: RTL

Runtime-configurable nearest-neighbour image scaler, the parametrised successor to the fixed-factor pixel-replication engine. On a start command it scans a source image in ROM once, reading each needed source pixel exactly once. It writes the scaled image into the VGA frame RAM through an explicit write strobe. Zoom factor, source dimensions and mode are latched per run, and the block reports busy/done/config-error status to the control FSM.

---
 rtl/rep_pixel_pkg.sv | 31 +++
 rtl/rep_pixel_addr_gen.sv | 59 +++++
 rtl/rep_pixel_scaler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rep_pixel_pkg.sv
`default_nettype none
//==============================================================================
// Module   : rep_pixel_pkg
// Brief    : Shared FSM states, mode encodings and width helpers for the
//            nearest-neighbour pixel scaler.
// Revision : 1.0 - initial release
//==============================================================================
package rep_pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_REP = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int c_max_fator = 4;
    localparam int c_src_w_max = 160;
    localparam int c_src_h_max = 120;

    // Source dimension ports are fixed at 10 bits; destination width needs room for x factor
    localparam int c_dim_w   = 10;
    localparam int c_fator_w = $clog2(c_max_fator + 1);
    localparam int c_dst_w   = c_dim_w + c_fator_w;
    localparam int c_src_pix = c_src_w_max * c_src_h_max;

endpackage
`default_nettype wire

// File: rtl/rep_pixel_addr_gen.sv
`default_nettype none
//==============================================================================
// Module   : rep_pixel_addr_gen
// Brief    : Combinational ROM read / RAM write address generator for one
//            scan position (linha, coluna, di, dj) under the latched config.
// Revision : 1.0 - initial release
//==============================================================================
module rep_pixel_addr_gen
    import rep_pixel_pkg::*;
#(
    parameter int FW     = 3,
    parameter int DIM_W  = 10,
    parameter int DST_W  = 13,
    parameter int ROM_AW = 19,
    parameter int RAM_AW = 19
)(
    input  logic [DIM_W-1:0]  linha,
    input  logic [DIM_W-1:0]  coluna,
    input  logic [FW-1:0]     di,
    input  logic [FW-1:0]     dj,
    input  logic [DIM_W-1:0]  largura,
    input  logic [FW-1:0]     fator,
    input  logic [DST_W-1:0]  dst_w,
    input  logic              mode,
    output logic [ROM_AW-1:0] addr_rom_nxt,
    output logic [RAM_AW-1:0] addr_ram_nxt
);

    logic [31:0] w_f;
    logic [31:0] w_src_row;
    logic [31:0] w_src_col;
    logic [31:0] w_dst_row;
    logic [31:0] w_dst_col;
    logic [31:0] w_rom_full;
    logic [31:0] w_ram_full;

    // Replicate: counters walk the source, fan out to F x F destination pixels.
    // Decimate: counters walk the destination, source is sampled at F stride.
    always_comb begin
        w_f       = 32'(fator);
        w_src_row = 32'(linha);
        w_src_col = 32'(coluna);
        w_dst_row = 32'(linha) * w_f + 32'(di);
        w_dst_col = 32'(coluna) * w_f + 32'(dj);
        if (mode == MODE_DEC) begin
            w_src_row = 32'(linha) * w_f;
            w_src_col = 32'(coluna) * w_f;
            w_dst_row = 32'(linha);
            w_dst_col = 32'(coluna);
        end
        w_rom_full = w_src_row * 32'(largura) + w_src_col;
        w_ram_full = w_dst_row * 32'(dst_w) + w_dst_col;
    end

    assign addr_rom_nxt = ROM_AW'(w_rom_full);
    assign addr_ram_nxt = RAM_AW'(w_ram_full);

endmodule
`default_nettype wire

// File: rtl/rep_pixel_scaler.sv
`default_nettype none
//==============================================================================
// Module   : rep_pixel_scaler
// Brief    : Runtime-configurable nearest-neighbour scaler, ROM -> VGA frame RAM.
// Config   : REP_PIXEL_DECIM_EN enables decimate (zoom-out) mode.
// Revision : 1.0 - initial release
//==============================================================================
module rep_pixel_scaler
    import rep_pixel_pkg::*;
#(
    parameter int MAX_FATOR = c_max_fator,
    parameter int SRC_W_MAX = c_src_w_max,
    parameter int SRC_H_MAX = c_src_h_max,
    parameter int PIX_W     = 8,
    parameter int ROM_AW    = 19,
    parameter int RAM_AW    = 19,
    parameter int ROM_LAT   = 1
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MAX_FATOR+1)-1:0] fator,
    input  logic                           mode,
    input  logic [c_dim_w-1:0]             largura,
    input  logic [c_dim_w-1:0]             altura,
    input  logic [PIX_W-1:0]               pixel_rom,
    output logic [ROM_AW-1:0]              addr_rom,
    output logic                           ram_we,
    output logic [RAM_AW-1:0]              addr_ram_vga,
    output logic [PIX_W-1:0]               pixel_saida,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    localparam int c_fw    = $clog2(MAX_FATOR + 1);
    localparam int c_dw    = c_dim_w + c_fw;
    localparam int c_lat_w = $clog2(ROM_LAT + 1);

    localparam logic [c_fw-1:0]    c_max_f = c_fw'(MAX_FATOR);
    localparam logic [c_dim_w-1:0] c_w_max = c_dim_w'(SRC_W_MAX);
    localparam logic [c_dim_w-1:0] c_h_max = c_dim_w'(SRC_H_MAX);
    localparam logic [c_lat_w-1:0] c_lat   = c_lat_w'(ROM_LAT);

    state_t              r_state;
    logic [c_dim_w-1:0]  r_linha, r_coluna, r_largura, r_cols, r_rows;
    logic [c_fw-1:0]     r_di, r_dj, r_fator, r_fmax;
    logic [c_dw-1:0]     r_dst_w;
    logic                r_mode;
    logic [c_lat_w-1:0]  r_rd_cnt;

    logic [c_dim_w-1:0]  w_linha_nxt, w_coluna_nxt, w_cols, w_rows;
    logic [c_fw-1:0]     w_di_nxt, w_dj_nxt, w_fmax;
    logic [c_dw-1:0]     w_dst_w;
    logic                w_mode, w_dec_ok, w_fator_ok, w_dims_ok, w_accept;
    logic                w_pix_last, w_scan_last;
    logic [ROM_AW-1:0]   w_rom_nxt;
    logic [RAM_AW-1:0]   w_ram_nxt;

    assign w_fator_ok = (fator != '0) && (fator <= c_max_f);
    assign w_dims_ok  = (largura != '0) && (altura != '0) &&
                        (largura <= c_w_max) && (altura <= c_h_max);
    assign w_accept   = w_fator_ok && w_dims_ok && w_dec_ok;

`ifdef REP_PIXEL_DECIM_EN
    logic [c_dim_w-1:0] w_fx, w_dw, w_dh;
    assign w_fx = c_dim_w'(fator);
    assign w_dw = (w_fx == '0) ? '0 : largura / w_fx;
    assign w_dh = (w_fx == '0) ? '0 : altura / w_fx;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    // Scan extents and per-pixel fan-out for the run being requested
    always_comb begin
        w_mode   = MODE_REP;
        w_dec_ok = 1'b1;
        w_cols   = largura;
        w_rows   = altura;
        w_fmax   = fator - 1'b1;
        w_dst_w  = c_dw'(largura) * c_dw'(fator);
`ifdef REP_PIXEL_DECIM_EN
        if (mode == MODE_DEC) begin
            w_mode   = MODE_DEC;
            w_dec_ok = (w_fx <= largura) && (w_fx <= altura);
            w_cols   = w_dw;
            w_rows   = w_dh;
            w_fmax   = '0;
            w_dst_w  = c_dw'(w_dw);
        end
`endif
    end

    assign w_pix_last  = (r_di == r_fmax) && (r_dj == r_fmax);
    assign w_scan_last = (r_linha == r_rows - 1'b1) && (r_coluna == r_cols - 1'b1);

    always_comb begin
        w_linha_nxt  = r_linha;
        w_coluna_nxt = r_coluna;
        w_di_nxt     = r_di;
        w_dj_nxt     = r_dj;
        if (r_state == WRITE) begin
            if (!w_pix_last) begin
                if (r_dj == r_fmax) begin
                    w_dj_nxt = '0;
                    w_di_nxt = r_di + 1'b1;
                end else begin
                    w_dj_nxt = r_dj + 1'b1;
                end
            end else if (!w_scan_last) begin
                w_di_nxt = '0;
                w_dj_nxt = '0;
                if (r_coluna == r_cols - 1'b1) begin
                    w_coluna_nxt = '0;
                    w_linha_nxt  = r_linha + 1'b1;
                end else begin
                    w_coluna_nxt = r_coluna + 1'b1;
                end
            end
        end
    end

    rep_pixel_addr_gen #(
        .FW     (c_fw),
        .DIM_W  (c_dim_w),
        .DST_W  (c_dw),
        .ROM_AW (ROM_AW),
        .RAM_AW (RAM_AW)
    ) u_addr_gen (
        .linha        (w_linha_nxt),
        .coluna       (w_coluna_nxt),
        .di           (w_di_nxt),
        .dj           (w_dj_nxt),
        .largura      (r_largura),
        .fator        (r_fator),
        .dst_w        (r_dst_w),
        .mode         (r_mode),
        .addr_rom_nxt (w_rom_nxt),
        .addr_ram_nxt (w_ram_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_linha      <= '0;
            r_coluna     <= '0;
            r_di         <= '0;
            r_dj         <= '0;
            r_largura    <= '0;
            r_cols       <= '0;
            r_rows       <= '0;
            r_fator      <= '0;
            r_fmax       <= '0;
            r_dst_w      <= '0;
            r_mode       <= MODE_REP;
            r_rd_cnt     <= '0;
            addr_rom     <= '0;
            addr_ram_vga <= '0;
            pixel_saida  <= '0;
            ram_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            ram_we  <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_accept) begin
                            r_largura <= largura;
                            r_fator   <= fator;
                            r_mode    <= w_mode;
                            r_cols    <= w_cols;
                            r_rows    <= w_rows;
                            r_fmax    <= w_fmax;
                            r_dst_w   <= w_dst_w;
                            r_linha   <= '0;
                            r_coluna  <= '0;
                            r_di      <= '0;
                            r_dj      <= '0;
                            r_rd_cnt  <= '0;
                            addr_rom  <= '0;
                            busy      <= 1'b1;
                            r_state   <= READ;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (r_rd_cnt == c_lat) begin
                        r_rd_cnt     <= '0;
                        pixel_saida  <= pixel_rom;
                        ram_we       <= 1'b1;
                        addr_ram_vga <= w_ram_nxt;
                        r_state      <= WRITE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    r_linha  <= w_linha_nxt;
                    r_coluna <= w_coluna_nxt;
                    r_di     <= w_di_nxt;
                    r_dj     <= w_dj_nxt;
                    if (!w_pix_last) begin
                        ram_we       <= 1'b1;
                        addr_ram_vga <= w_ram_nxt;
                    end else if (w_scan_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        addr_rom <= w_rom_nxt;
                        r_state  <= READ;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
